// File: rtl/output_port_receiver.sv
// output_port_receiver
//   Receiving end of the CPU output port. Each CPU output-load strobe pushes
//   one word into a small FIFO. The push happens one cycle after the strobe,
//   when the CPU output register holds the new value. A downstream consumer
//   drains the FIFO over a valid/ready handshake. A word that arrives while
//   the FIFO is full and not being popped is dropped, and a sticky Overflow
//   flag is set.
// Ports
//   Clk       rising-edge clock
//   Reset     asynchronous, active-high
//   Out_Ld    CPU output-load strobe (one push per high cycle, one cycle later)
//   Out_Data  CPU output-register value, sampled in the cycle after Out_Ld
//   Dout      head-of-FIFO word, 0 when Valid=0
//   Valid     Dout holds an unread word
//   Ready     consumer accepts Dout this cycle
//   Count     number of stored entries, 0..Depth
//   Full      Count == Depth
//   Overflow  sticky word-dropped flag
//   Clr_Ovf   synchronous clear of Overflow (a same-cycle drop wins)
module output_port_receiver #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned DepthBits = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Out_Ld,
  input  logic [DataWidth-1:0] Out_Data,
  output logic [DataWidth-1:0] Dout,
  output logic                 Valid,
  input  logic                 Ready,
  output logic [DepthBits:0]   Count,
  output logic                 Full,
  output logic                 Overflow,
  input  logic                 Clr_Ovf
);

  localparam int unsigned Depth = 2 ** DepthBits;
  localparam int unsigned CntW  = DepthBits + 1;

  logic                 pend_q;
  logic [DepthBits-1:0] wr_ptr_q, wr_ptr_d;
  logic [DepthBits-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [DataWidth-1:0] mem_q [Depth];

  logic pop_c;
  logic push_c;
  logic drop_c;

  // Status outputs decode directly from registered state.
  assign Count = count_q;
  assign Valid = (count_q != '0);
  assign Full  = (count_q == CntW'(Depth));
  assign Overflow = ovf_q;
  assign Dout  = Valid ? mem_q[rd_ptr_q] : '0;

  // Handshake decisions. A pop frees a slot in the same cycle, so a full FIFO
  // can still accept a word while it is being drained.
  always_comb begin
    pop_c  = Valid & Ready;
    push_c = pend_q & (~Full | pop_c);
    drop_c = pend_q & Full & ~pop_c;
  end

  // Next-state computation for pointers, occupancy and overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_c) wr_ptr_d = wr_ptr_q + DepthBits'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + DepthBits'(1);
    count_d = count_q + CntW'(push_c) - CntW'(pop_c);
    if (drop_c)       ovf_d = 1'b1;
    else if (Clr_Ovf) ovf_d = 1'b0;
  end

  // Control state; reset also discards any pending strobe.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pend_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      pend_q   <= Out_Ld;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array is not reset; Valid gating hides stale contents.
  always_ff @(posedge Clk) begin
    if (push_c) mem_q[wr_ptr_q] <= Out_Data;
  end

endmodule
